// File: rtl/ta_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ta_sync_pkg
// Brief   : Shared types, error codes and mask helper for the multi-channel
//           capture synchroniser.
// Revision: 1.0 - initial release
// ============================================================================
package ta_sync_pkg;

    // Widest channel mask the helper function accepts
    localparam int MAX_CH = 16;

    // Controller states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MRST      = 3'd1,
        WAIT_CMPT = 3'd2,
        CHECK     = 3'd3,
        LDD       = 3'd4,
        DONE      = 3'd5
    } state_e;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_TMO   = 2'b01;
    localparam logic [1:0] ERR_PHASE = 2'b10;

    // Index of the lowest set bit of a mask; 0 when the mask is empty
    function automatic int lowest_set(input logic [MAX_CH-1:0] mask);
        int idx;
        idx = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ta_sync_collect.sv
`default_nettype none
// ============================================================================
// Module  : ta_sync_collect
// Brief   : Per-channel completion flags and phase latches, with all-done,
//           missing-channel and phase-mismatch detection.
// Revision: 1.0 - initial release
// ============================================================================
module ta_sync_collect
    import ta_sync_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int CAP0_1 = 2
) (
    input  logic                     clk50,
    input  logic                     rst,
    input  logic                     clr_i,        // clear completion flags
    input  logic                     sample_i,     // completions are sampled
    input  logic [CH_NUM-1:0]        en_i,         // latched channel enables
    input  logic [CH_NUM-1:0]        cap_cmpt_i,
    input  logic [CH_NUM*CAP0_1-1:0] cap_phase_i,
    output logic                     all_done_o,   // includes this cycle's hits
    output logic [CH_NUM-1:0]        missing_o,    // enabled, still not done
    output logic [CH_NUM-1:0]        mismatch_o    // phase differs from reference
);

    logic [CH_NUM-1:0] done_q;
    logic [CH_NUM-1:0] done_d;
    logic [CH_NUM-1:0] hit;
    logic [CAP0_1-1:0] phase_q [CH_NUM];
    logic [MAX_CH-1:0] mask16;
    logic [CAP0_1-1:0] ref_ph;
    int                ref_idx;

    // A completion only counts for enabled channels while sampling is open
    assign hit = sample_i ? (cap_cmpt_i & en_i) : '0;

    // Next-state of the done flags: cleared during memory reset, else sticky
    always_comb begin
        done_d = done_q | hit;
        if (clr_i) begin
            done_d = '0;
        end
    end

    // Done flag register
    always_ff @(posedge clk50) begin
        if (rst) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    // Phase latches capture only on a channel's first completion
    always_ff @(posedge clk50) begin
        for (int i = 0; i < CH_NUM; i++) begin
            if (rst) begin
                phase_q[i] <= '0;
            end else if (hit[i] && !done_q[i]) begin
                phase_q[i] <= cap_phase_i[i*CAP0_1 +: CAP0_1];
            end
        end
    end

    // Completion summary, counting completions arriving this very cycle
    always_comb begin
        all_done_o = (((done_q | hit) & en_i) == en_i);
        missing_o  = en_i & ~(done_q | hit);
    end

    // Compare every enabled channel with the lowest-index enabled channel
    always_comb begin
        mask16               = '0;
        mask16[CH_NUM-1:0]   = en_i;
        ref_idx              = lowest_set(mask16);
        ref_ph               = '0;
        mismatch_o           = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (i == ref_idx) begin
                ref_ph = phase_q[i];
            end
        end
        for (int i = 0; i < CH_NUM; i++) begin
            if (en_i[i] && (phase_q[i] != ref_ph)) begin
                mismatch_o[i] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ta_sync_mc.sv
`default_nettype none
// ============================================================================
// Module  : ta_sync_mc
// Brief   : Multi-channel capture synchroniser: accepts a capture request,
//           clears capture memory, waits for enabled channels to complete,
//           checks phase agreement, strobes merge and hands off to the loader.
// Revision: 1.0 - initial release
// ============================================================================
module ta_sync_mc
    import ta_sync_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int CAP0_1  = 2,
    parameter int RST_CYC = 16,
    parameter int TMO_W   = 20,
    parameter int TMO_CYC = 500000
) (
    input  logic                     clk50,
    input  logic                     rst,
    input  logic                     cap_trig,
    output logic                     capr_rdy,
    input  logic [CH_NUM-1:0]        ch_en,
    input  logic                     mode,
    input  logic [CH_NUM-1:0]        cap_cmpt,
    input  logic [CH_NUM*CAP0_1-1:0] cap_phase,
    input  logic                     stop,
    output logic                     mem_reset,
    output logic                     merge_en,
    output logic                     ldd_trig,
    input  logic                     lddr_rdy,
    output logic                     sync_err,
    output logic [1:0]               err_code,
    output logic [CH_NUM-1:0]        err_ch
);

    localparam int                 RCNT_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCNT_W-1:0]  RCNT_LAST = RCNT_W'(RST_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TMO_CYC - 1);

    state_e              state_q;
    state_e              state_d;
    logic [RCNT_W-1:0]   rcnt_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [CH_NUM-1:0]   en_q;
    logic                mode_q;
    logic                stop_q;
    logic                sync_err_q;
    logic [1:0]          err_code_q;
    logic [CH_NUM-1:0]   err_ch_q;

    logic                accept;
    logic                tmo_fire;
    logic                phase_fail;
    logic                all_done;
    logic [CH_NUM-1:0]   missing;
    logic [CH_NUM-1:0]   mismatch;

    ta_sync_collect #(
        .CH_NUM (CH_NUM),
        .CAP0_1 (CAP0_1)
    ) u_collect (
        .clk50       (clk50),
        .rst         (rst),
        .clr_i       (state_q == MRST),
        .sample_i    (state_q == WAIT_CMPT),
        .en_i        (en_q),
        .cap_cmpt_i  (cap_cmpt),
        .cap_phase_i (cap_phase),
        .all_done_o  (all_done),
        .missing_o   (missing),
        .mismatch_o  (mismatch)
    );

    // Next-state and strobe outputs; strobes are gated so reset dominates
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        tmo_fire   = 1'b0;
        phase_fail = 1'b0;
        capr_rdy   = 1'b0;
        mem_reset  = 1'b0;
        merge_en   = 1'b0;
        ldd_trig   = 1'b0;
        case (state_q)
            IDLE: begin
                capr_rdy = (ch_en != '0);
                if (cap_trig && (ch_en != '0)) begin
                    accept  = 1'b1;
                    state_d = MRST;
                end
            end
            MRST: begin
                mem_reset = 1'b1;
                if (rcnt_q == RCNT_LAST) begin
                    state_d = WAIT_CMPT;
                end
            end
            WAIT_CMPT: begin
                // Completion wins over a timeout landing in the same cycle
                if (all_done) begin
                    state_d = CHECK;
                end else if (tmo_q >= TMO_LAST) begin
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            CHECK: begin
                if (mismatch != '0) begin
                    phase_fail = 1'b1;
                    state_d    = IDLE;
                end else begin
                    merge_en = 1'b1;
                    state_d  = LDD;
                end
            end
            LDD: begin
                ldd_trig = 1'b1;
                if (lddr_rdy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = (mode_q && !stop_q && !stop) ? MRST : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            accept     = 1'b0;
            tmo_fire   = 1'b0;
            phase_fail = 1'b0;
            capr_rdy   = 1'b0;
            mem_reset  = 1'b0;
            merge_en   = 1'b0;
            ldd_trig   = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, request context, stop flag and error reporting
    always_ff @(posedge clk50) begin
        if (rst) begin
            rcnt_q     <= '0;
            tmo_q      <= '0;
            en_q       <= '0;
            mode_q     <= 1'b0;
            stop_q     <= 1'b0;
            sync_err_q <= 1'b0;
            err_code_q <= ERR_NONE;
            err_ch_q   <= '0;
        end else begin
            sync_err_q <= 1'b0;

            if (accept) begin
                en_q       <= ch_en;
                mode_q     <= mode;
                stop_q     <= 1'b0;
                err_code_q <= ERR_NONE;
                err_ch_q   <= '0;
            end else if (mode_q && stop) begin
                stop_q <= 1'b1;
            end

            // Memory-reset length counter restarts on every MRST entry
            if ((state_q == MRST) && (state_d == MRST)) begin
                rcnt_q <= rcnt_q + 1'b1;
            end else begin
                rcnt_q <= '0;
            end

            // Timeout counter saturates rather than wrapping
            if (state_q == WAIT_CMPT) begin
                if (tmo_q != '1) begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end

            if (tmo_fire) begin
                sync_err_q <= 1'b1;
                err_code_q <= ERR_TMO;
                err_ch_q   <= missing;
            end else if (phase_fail) begin
                sync_err_q <= 1'b1;
                err_code_q <= ERR_PHASE;
                err_ch_q   <= mismatch;
            end
        end
    end

    assign sync_err = sync_err_q;
    assign err_code = err_code_q;
    assign err_ch   = err_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_ta_sync_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_ta_sync_mc
// Brief   : Self-checking bench for ta_sync_mc; merge, transfer and error
//           events are checked against an expected-event queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ta_sync_mc;

    localparam int CH = 4;
    localparam int PW = 2;
    localparam int RC = 16;
    localparam int TW = 20;
    localparam int TC = 100;

    localparam int EV_MERGE = 0;
    localparam int EV_XFER  = 1;
    localparam int EV_ERR   = 2;

    logic              clk50     = 1'b0;
    logic              rst       = 1'b1;
    logic              cap_trig  = 1'b0;
    logic              mode      = 1'b0;
    logic              stop      = 1'b0;
    logic              lddr_rdy  = 1'b0;
    logic [CH-1:0]     ch_en     = 4'b1111;
    logic [CH-1:0]     cap_cmpt  = '0;
    logic [CH*PW-1:0]  cap_phase = '0;
    logic              capr_rdy;
    logic              mem_reset;
    logic              merge_en;
    logic              ldd_trig;
    logic              sync_err;
    logic [1:0]        err_code;
    logic [CH-1:0]     err_ch;

    ta_sync_mc #(
        .CH_NUM  (CH),
        .CAP0_1  (PW),
        .RST_CYC (RC),
        .TMO_W   (TW),
        .TMO_CYC (TC)
    ) dut (
        .clk50     (clk50),
        .rst       (rst),
        .cap_trig  (cap_trig),
        .capr_rdy  (capr_rdy),
        .ch_en     (ch_en),
        .mode      (mode),
        .cap_cmpt  (cap_cmpt),
        .cap_phase (cap_phase),
        .stop      (stop),
        .mem_reset (mem_reset),
        .merge_en  (merge_en),
        .ldd_trig  (ldd_trig),
        .lddr_rdy  (lddr_rdy),
        .sync_err  (sync_err),
        .err_code  (err_code),
        .err_ch    (err_ch)
    );

    always #5 clk50 = ~clk50;

    typedef struct {
        int            kind;
        int            at;
        logic [1:0]    code;
        logic [CH-1:0] ch;
    } ev_t;

    ev_t sbq[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    int  t0     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int at, input logic [1:0] code,
                             input logic [CH-1:0] ch);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.code = code;
        e.ch   = ch;
        sbq.push_back(e);
    endtask

    task automatic take(input int kind);
        ev_t e;
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected: observed event %0d at cycle %0d, expected none", kind, cyc);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            assert ((kind === e.kind) && (cyc === e.at)) else begin
                errors++;
                $error("FAIL sb_event: observed kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                       kind, cyc, e.kind, e.at);
            end
            if (kind == EV_ERR) begin
                checks++;
                assert ({err_code, err_ch} === {e.code, e.ch}) else begin
                    errors++;
                    $error("FAIL sb_err: observed code=%b ch=%b, expected code=%b ch=%b",
                           err_code, err_ch, e.code, e.ch);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        cyc++;
        #1;
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic look();
        @(negedge clk50);
    endtask

    // Output monitor: every strobe must match the head of the expected queue
    always @(negedge clk50) begin
        if (!rst) begin
            if (merge_en)             take(EV_MERGE);
            if (ldd_trig && lddr_rdy) take(EV_XFER);
            if (sync_err)             take(EV_ERR);
        end
    end

    initial begin
        // Reset state
        tick(); tick(); look();
        chk("rst_capr",     32'(capr_rdy),  0);
        chk("rst_mem",      32'(mem_reset), 0);
        chk("rst_ldd",      32'(ldd_trig),  0);
        chk("rst_sync_err", 32'(sync_err),  0);
        chk("rst_err_code", 32'(err_code),  0);
        chk("rst_err_ch",   32'(err_ch),    0);
        tick(); rst = 1'b0; look();
        chk("idle_capr", 32'(capr_rdy), 1);

        // Empty enable mask blocks acceptance
        tick(); ch_en = 4'b0000; cap_trig = 1'b1; look();
        chk("zero_en_capr", 32'(capr_rdy), 0);
        tick(); cap_trig = 1'b0; ch_en = 4'b1111; look();
        chk("zero_en_ignored", 32'(capr_rdy), 1);
        chk("zero_en_no_mrst", 32'(mem_reset), 0);

        // Single shot, all channels, phases agree
        tick(); t0 = cyc; mode = 1'b0; cap_phase = 8'b01_01_01_01; cap_trig = 1'b1;
        tick(); cap_trig = 1'b0;
        for (int k = 1; k <= RC + 1; k++) begin
            to_cyc(t0 + k); look();
            chk($sformatf("mem_reset_c%0d", k), 32'(mem_reset), 32'(k <= RC));
        end
        to_cyc(t0 + 20); cap_cmpt = 4'b1111; expect_ev(EV_MERGE, t0 + 21, 2'b00, '0);
        tick(); cap_cmpt = '0;
        to_cyc(t0 + 22); look();
        chk("ldd_on", 32'(ldd_trig), 1);
        to_cyc(t0 + 25); lddr_rdy = 1'b1; expect_ev(EV_XFER, t0 + 25, 2'b00, '0);
        tick(); lddr_rdy = 1'b0; look();
        chk("ldd_off",   32'(ldd_trig), 0);
        chk("done_capr", 32'(capr_rdy), 0);
        to_cyc(t0 + 27); look();
        chk("capr_back", 32'(capr_rdy), 1);

        // Masked channels; channel 1 completion with odd phase is ignored
        tick(); t0 = cyc; ch_en = 4'b0101; cap_trig = 1'b1;
        tick(); cap_trig = 1'b0;
        to_cyc(t0 + 18); cap_cmpt = 4'b0001; cap_phase = 8'b00_00_00_01;
        tick();          cap_cmpt = 4'b0010; cap_phase = 8'b00_00_11_01;
        tick();          cap_cmpt = 4'b0101; cap_phase = 8'b00_01_11_11;
        expect_ev(EV_MERGE, t0 + 21, 2'b00, '0);
        tick(); cap_cmpt = '0; lddr_rdy = 1'b1; expect_ev(EV_XFER, t0 + 22, 2'b00, '0);
        to_cyc(t0 + 23); lddr_rdy = 1'b0;
        to_cyc(t0 + 24); look();
        chk("masked_capr",     32'(capr_rdy), 1);
        chk("masked_err_code", 32'(err_code), 0);

        // Timeout: channel 3 never completes; cap_trig in WAIT_CMPT ignored
        tick(); t0 = cyc; ch_en = 4'b1111; cap_phase = 8'b01_01_01_01; cap_trig = 1'b1;
        tick(); cap_trig = 1'b0;
        to_cyc(t0 + 18); cap_cmpt = 4'b0111;
        tick(); cap_cmpt = '0;
        to_cyc(t0 + 30); cap_trig = 1'b1; look();
        chk("wait_capr", 32'(capr_rdy), 0);
        tick(); cap_trig = 1'b0; look();
        chk("wait_no_mrst", 32'(mem_reset), 0);
        expect_ev(EV_ERR, t0 + 17 + TC, 2'b01, 4'b1000);
        to_cyc(t0 + 120); look();
        chk("tmo_code_held", 32'(err_code), 1);
        chk("tmo_ch_held",   32'(err_ch),   8);
        chk("tmo_capr",      32'(capr_rdy), 1);

        // Phase mismatch on channel 2; loader held ready to expose any ldd_trig
        tick(); t0 = cyc; cap_phase = 8'b01_11_01_01; cap_trig = 1'b1; lddr_rdy = 1'b1;
        tick(); cap_trig = 1'b0; look();
        chk("accept_clr_code", 32'(err_code), 0);
        chk("accept_clr_ch",   32'(err_ch),   0);
        to_cyc(t0 + 17); cap_cmpt = 4'b1111; expect_ev(EV_ERR, t0 + 19, 2'b10, 4'b0100);
        tick(); cap_cmpt = '0;
        to_cyc(t0 + 22); lddr_rdy = 1'b0; look();
        chk("mm_capr", 32'(capr_rdy), 1);

        // Continuous mode: two runs, stop during the second LDD
        tick(); t0 = cyc; ch_en = 4'b0011; mode = 1'b1; cap_phase = 8'b00_00_10_10; cap_trig = 1'b1;
        tick(); cap_trig = 1'b0; mode = 1'b0;
        to_cyc(t0 + 17); cap_cmpt = 4'b0011; expect_ev(EV_MERGE, t0 + 18, 2'b00, '0);
        tick(); cap_cmpt = '0; lddr_rdy = 1'b1; expect_ev(EV_XFER, t0 + 19, 2'b00, '0);
        to_cyc(t0 + 20); lddr_rdy = 1'b0; look();
        chk("cont_done_capr", 32'(capr_rdy), 0);
        to_cyc(t0 + 21); look();
        chk("cont_rearm", 32'(mem_reset), 1);
        to_cyc(t0 + 37); cap_cmpt = 4'b0011; expect_ev(EV_MERGE, t0 + 38, 2'b00, '0);
        tick(); cap_cmpt = '0;
        to_cyc(t0 + 40); stop = 1'b1;
        tick(); stop = 1'b0; lddr_rdy = 1'b1; expect_ev(EV_XFER, t0 + 41, 2'b00, '0);
        tick(); lddr_rdy = 1'b0;
        to_cyc(t0 + 43); look();
        chk("cont_stop_idle", 32'(capr_rdy), 1);
        to_cyc(t0 + 44); look();
        chk("cont_no_rearm", 32'(mem_reset), 0);

        // Reset while ldd_trig is pending
        tick(); t0 = cyc; ch_en = 4'b0001; cap_phase = '0; cap_trig = 1'b1;
        tick(); cap_trig = 1'b0;
        to_cyc(t0 + 17); cap_cmpt = 4'b0001; expect_ev(EV_MERGE, t0 + 18, 2'b00, '0);
        tick(); cap_cmpt = '0;
        to_cyc(t0 + 20); look();
        chk("ldd_pending", 32'(ldd_trig), 1);
        to_cyc(t0 + 21); rst = 1'b1; look();
        chk("rst_cycle_ldd",  32'(ldd_trig), 0);
        chk("rst_cycle_capr", 32'(capr_rdy), 0);
        tick(); rst = 1'b0; look();
        chk("post_rst_ldd",      32'(ldd_trig), 0);
        chk("post_rst_capr",     32'(capr_rdy), 1);
        chk("post_rst_err_code", 32'(err_code), 0);

        // Every expected event must have been observed
        tick(); look();
        checks++;
        assert (sbq.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover: observed %0d pending events, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ta_sync_mc.md
Name: ta_sync_mc

Overview:
Multi-channel capture synchroniser and the parametrised successor of the two-domain capture/sync controller. It accepts one capture request and clears capture memory. It then collects per-channel capture-complete flags from CH_NUM channels and checks that their captured phases agree. On agreement it raises merge_en and hands off to the laser-diode-driver loader over a valid/ready handshake. New capabilities: channel enable mask, completion timeout with error reporting, phase-mismatch detection, and a continuous re-arm mode.

Parameters:
CH_NUM, 4, number of capture channels (1..16)
CAP0_1, 2, width of each channel's cap_phase field
RST_CYC, 16, length of mem_reset in clk50 cycles (>=1)
TMO_W, 20, width of the completion timeout counter
TMO_CYC, 500000, cycles allowed in WAIT_CMPT before timeout (< 2**TMO_W)

Ports:
clk50  in  1  sole clock
rst  in  1  synchronous, active-high reset
cap_trig  in  1  capture request; accepted only when capr_rdy=1
capr_rdy  out  1  ready for a new request
ch_en  in  CH_NUM  channel enable mask, sampled at accept
mode  in  1  0=single shot, 1=continuous re-arm; sampled at accept
cap_cmpt  in  CH_NUM  per-channel capture-complete pulse or level
cap_phase  in  CH_NUM*CAP0_1  per-channel phase; channel i occupies bits [i*CAP0_1 +: CAP0_1]
stop  in  1  exit continuous mode at the next DONE
mem_reset  out  1  capture-memory clear
merge_en  out  1  one-cycle merge strobe
ldd_trig  out  1  loader request (valid)
lddr_rdy  in  1  loader ready
sync_err  out  1  one-cycle error strobe
err_code  out  2  01=timeout, 10=phase mismatch; held until next accept
err_ch  out  CH_NUM  timeout: enabled channels not complete; mismatch: channels whose phase differs from the lowest enabled channel

Behaviour:
- Reset, synchronous, dominates everything: state=IDLE, capr_rdy=0 in the reset cycle then 1 in IDLE, mem_reset=0, merge_en=0, ldd_trig=0, sync_err=0, err_code=0, err_ch=0, all counters and sticky flags=0, en_q=0, mode_q=0.
- Reset mid-operation aborts immediately. No pending ldd_trig survives reset.
- capr_rdy = (state==IDLE) && (ch_en!=0).
- Accept happens when cap_trig && capr_rdy. On accept: en_q<=ch_en, mode_q<=mode, err_code<=0, err_ch<=0, go to MRST.
- cap_trig is ignored in every state except IDLE.
- MRST: mem_reset=1 for exactly RST_CYC cycles, counted from the cycle after accept. Done flags clear. Then go to WAIT_CMPT.
- WAIT_CMPT: done[i] <= done[i] | (cap_cmpt[i] & en_q[i]). Phase of channel i latches on the first cycle its cap_cmpt is seen. Disabled channels are ignored. The timeout counter increments each cycle.
  - If all enabled channels are done, go to CHECK. Completion that occurs in the same cycle as the timeout counter reaching TMO_CYC-1 counts as success.
  - Otherwise, on reaching TMO_CYC: sync_err=1 for one cycle, err_code=01, err_ch=en_q & ~done, go to IDLE.
- CHECK (1 cycle): compare each enabled channel's latched phase with the lowest-index enabled channel.
  - If all are equal: merge_en=1 for that one cycle, go to LDD.
  - On any mismatch: sync_err pulse, err_code=10, err_ch=mismatch mask, go to IDLE. No merge_en and no ldd_trig are issued.
- LDD: ldd_trig=1, held until the cycle in which lddr_rdy=1. The transfer happens in that cycle, and ldd_trig drops the next cycle. If lddr_rdy is already high on entry, the transfer completes in one cycle. There is no timeout in LDD.
- DONE (1 cycle): go to MRST if mode_q=1 and stop=0; otherwise go to IDLE.
  - stop asserted at any time while mode_q=1 sets a sticky flag. The flag forces IDLE at the next DONE and clears on accept.
  - stop has no effect in single-shot mode.
- Latency, single shot with all channels completing immediately: accept at cycle 0, mem_reset in cycles 1..RST_CYC, CHECK at RST_CYC+2, ldd_trig from RST_CYC+3.
- Width rule: the timeout counter saturates and does not wrap. CH_NUM=1 means the mismatch check always passes.
- Phase of a channel whose cap_cmpt arrives during MRST is not captured. Only WAIT_CMPT samples completions.

Decomposition:
- Package ta_sync_pkg holds the following.
  - State enum: IDLE, MRST, WAIT_CMPT, CHECK, LDD, DONE.
  - Error code constants: ERR_NONE=00, ERR_TMO=01, ERR_PHASE=10.
  - A function returning the lowest set bit index of a mask.
- One natural sub-module: ta_sync_collect. It holds the per-channel done flags, phase latches, all-done detect, the mismatch mask and the missing mask. It is instantiated once. The FSM and counters stay in the top.

Test Plan:
- Single shot, RST_CYC=16, CH_NUM=4, ch_en=1111, all cap_cmpt at cycle 20 with phase 2'b01 -> mem_reset high for cycles 1..16; merge_en pulse at cycle 21; ldd_trig from cycle 22; lddr_rdy at cycle 25 -> ldd_trig low at 26; capr_rdy back high at 27.
- Masked channels: ch_en=0101; cap_cmpt only on channels 0 and 2 -> success. cap_cmpt on channel 1 with a differing phase -> ignored, no error.
- Timeout, TMO_CYC=100: channel 3 never completes -> sync_err pulse 100 cycles into WAIT_CMPT, err_code=01, err_ch=1000, no merge_en.
- Phase mismatch: phases 01,01,11,01 -> sync_err, err_code=10, err_ch=0100, no ldd_trig.
- Continuous mode: mode=1, two full runs back-to-back with no cap_trig in between; stop asserted during the second LDD -> returns to IDLE after the second DONE.
- Reset asserted mid-LDD while ldd_trig=1 -> next cycle ldd_trig=0, state IDLE. cap_trig during WAIT_CMPT -> ignored. ch_en=0 -> capr_rdy=0.
